// File: rtl/pcileech_tx_scheduler.sv
// Arbitrates the TLP and CFG receive FIFOs onto the 256-bit FT601 path, packing seven tagged
// DWORDs plus a status DWORD per word and flushing partial words after an idle timeout.
module pcileech_tx_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  tlp_data,
    input  logic         tlp_last,
    input  logic         tlp_valid,
    input  logic         tlp_empty,
    output logic         tlp_rd_en,
    input  logic [31:0]  cfg_data,
    input  logic         cfg_valid,
    input  logic         cfg_empty,
    output logic         cfg_rd_en,
    output logic [255:0] out_data,
    output logic         out_valid,
    input  logic         out_rd_en
);

    typedef enum logic [1:0] {StIdle, StTlp, StCfg} grant_e;

    localparam logic [7:0] IdleMax = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] FlushAt = 8'(TIMEOUT_CYCLES - 2);

    grant_e         grant_q, grant_d;
    logic           rr_q, rr_d;
    logic           cfg_pend_q, cfg_pend_d;
    logic           inflight_q;
    logic [2:0]     filled_q, filled_d;
    logic [7:0]     idle_q, idle_d;
    logic [31:0]    slot_data_q [7];
    logic [3:0]     slot_tag_q [7];
    logic [255:0]   out_data_q, out_data_d;
    logic           out_valid_q;

    logic           room;
    logic           tlp_arr, cfg_arr, arrival;
    logic [31:0]    arr_data;
    logic [3:0]     arr_tag;
    logic           full_emit, flush, emit;

    // Valids only count when a read was issued last cycle; this also drops stray
    // valids on the first cycle out of reset. TLP wins a simultaneous arrival.
    assign room    = ({1'b0, filled_q} + {3'b000, inflight_q}) < 4'd7;
    assign tlp_arr = inflight_q & tlp_valid;
    assign cfg_arr = inflight_q & cfg_valid & ~tlp_valid;
    assign arrival = tlp_arr | cfg_arr;

    always_comb begin
        grant_d    = grant_q;
        rr_d       = rr_q;
        cfg_pend_d = cfg_pend_q;
        tlp_rd_en  = 1'b0;
        cfg_rd_en  = 1'b0;
        unique case (grant_q)
            StIdle: begin
                if (!tlp_empty && !cfg_empty) begin
                    grant_d = rr_q ? StCfg : StTlp;
                    rr_d    = ~rr_q;
                end else if (!tlp_empty) begin
                    grant_d = StTlp;
                end else if (!cfg_empty) begin
                    grant_d = StCfg;
                end
            end
            StTlp: begin
                tlp_rd_en = !tlp_empty && out_rd_en && room;
                // A read issued alongside the last DWORD keeps the grant for the next TLP.
                if (tlp_arr && tlp_last && !tlp_rd_en) begin
                    grant_d = StIdle;
                end
            end
            StCfg: begin
                cfg_rd_en = !cfg_empty && out_rd_en && room && !cfg_pend_q;
                if (cfg_rd_en) begin
                    cfg_pend_d = 1'b1;
                end else if (cfg_pend_q && inflight_q && cfg_valid) begin
                    cfg_pend_d = 1'b0;
                    grant_d    = StIdle;
                end
            end
            default: grant_d = StIdle;
        endcase
    end

    always_comb begin
        arr_data  = tlp_valid ? tlp_data : cfg_data;
        arr_tag   = tlp_valid ? (tlp_last ? 4'h2 : 4'h1) : 4'h3;
        full_emit = (filled_q == 3'd7) && out_rd_en;
        // Fires on the cycle the counter would reach TIMEOUT_CYCLES-1.
        flush     = (filled_q != 3'd0) && !inflight_q && !arrival && out_rd_en &&
                    (idle_q >= FlushAt);
        emit      = full_emit || flush;

        out_data_d = out_data_q;
        if (emit) begin
            for (int i = 0; i < 7; i++) begin
                if (3'(i) < filled_q) begin
                    out_data_d[32*i +: 32]    = slot_data_q[i];
                    out_data_d[224+4*i +: 4]  = slot_tag_q[i];
                end else begin
                    out_data_d[32*i +: 32]    = 32'h0;
                    out_data_d[224+4*i +: 4]  = 4'hF;
                end
            end
            out_data_d[255:252] = 4'hE;
        end

        if (emit) begin
            filled_d = 3'd0;
        end else if (arrival) begin
            filled_d = filled_q + 3'd1;
        end else begin
            filled_d = filled_q;
        end

        if (arrival || emit) begin
            idle_d = 8'd0;
        end else if ((filled_q != 3'd0) && !inflight_q && (idle_q < IdleMax)) begin
            idle_d = idle_q + 8'd1;
        end else begin
            idle_d = idle_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q     <= StIdle;
            rr_q        <= 1'b0;
            cfg_pend_q  <= 1'b0;
            inflight_q  <= 1'b0;
            filled_q    <= 3'd0;
            idle_q      <= 8'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                slot_data_q[i] <= 32'h0;
                slot_tag_q[i]  <= 4'h0;
            end
        end else begin
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            cfg_pend_q  <= cfg_pend_d;
            inflight_q  <= tlp_rd_en | cfg_rd_en;
            filled_q    <= filled_d;
            idle_q      <= idle_d;
            out_data_q  <= out_data_d;
            out_valid_q <= emit;
            if (arrival && !emit) begin
                slot_data_q[filled_q] <= arr_data;
                slot_tag_q[filled_q]  <= arr_tag;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pcileech_tx_scheduler.sv
// Scoreboard bench: source FIFO models feed the scheduler; a monitor unpacks every emitted word
// and checks it against expected words and per-source expected DWORD streams.
module tb_pcileech_tx_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  tlp_data = 32'h0;
    logic         tlp_last = 1'b0;
    logic         tlp_valid = 1'b0;
    logic         tlp_empty = 1'b1;
    logic         tlp_rd_en;
    logic [31:0]  cfg_data = 32'h0;
    logic         cfg_valid = 1'b0;
    logic         cfg_empty = 1'b1;
    logic         cfg_rd_en;
    logic [255:0] out_data;
    logic         out_valid;
    logic         out_rd_en = 1'b1;

    logic [32:0]  tlp_fifo [$];
    logic [31:0]  cfg_fifo [$];
    logic [32:0]  exp_tlp [$];
    logic [31:0]  exp_cfg [$];
    logic [255:0] exp_words [$];
    bit           tlp_hide = 1'b0;
    bit           cfg_hide = 1'b0;
    int           tlp_pops = 0;
    int           n_vec = 0;
    int           n_err = 0;
    bit           in_tlp = 1'b0;
    bit           prev_ov = 1'b0;
    bit           prev_arr = 1'b0;
    bit           t_rd = 1'b0;
    bit           c_rd = 1'b0;

    always #5 clk = ~clk;

    pcileech_tx_scheduler #(.TIMEOUT_CYCLES(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .tlp_data  (tlp_data),
        .tlp_last  (tlp_last),
        .tlp_valid (tlp_valid),
        .tlp_empty (tlp_empty),
        .tlp_rd_en (tlp_rd_en),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_empty (cfg_empty),
        .cfg_rd_en (cfg_rd_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_rd_en (out_rd_en)
    );

    function automatic void chk(input string name, input logic [255:0] act,
                                input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic push_tlp(input logic [31:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            tlp_fifo.push_back({i == len - 1, base + 32'(i)});
            exp_tlp.push_back({i == len - 1, base + 32'(i)});
        end
    endtask

    task automatic push_cfg(input logic [31:0] d);
        cfg_fifo.push_back(d);
        exp_cfg.push_back(d);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_words.size() + exp_tlp.size() + exp_cfg.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_drained"}, 256'(exp_words.size() + exp_tlp.size() + exp_cfg.size()),
            256'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_word(input logic [255:0] w);
        logic [31:0] st;
        logic [3:0]  tg;
        logic [31:0] d;
        logic [32:0] et;
        logic [31:0] ec;
        int          used;
        bit          filler;
        st     = w[255:224];
        used   = 0;
        filler = 1'b0;
        chk("status_hdr", 256'(st[31:28]), 256'hE);
        if (exp_words.size() != 0) chk("word", w, exp_words.pop_front());
        for (int i = 0; i < 7; i++) begin
            tg = st[4*i +: 4];
            d  = w[32*i +: 32];
            if (tg == 4'hF) begin
                filler = 1'b1;
                chk("filler_data", 256'(d), 256'd0);
            end else begin
                used++;
                chk("filler_only_at_end", 256'(filler), 256'd0);
                if (tg == 4'h1 || tg == 4'h2) begin
                    chk("tlp_expected", 256'(exp_tlp.size() != 0), 256'd1);
                    if (exp_tlp.size() != 0) begin
                        et = exp_tlp.pop_front();
                        chk("tlp_dword", 256'({tg == 4'h2, d}), 256'(et));
                    end
                    in_tlp = (tg == 4'h1);
                end else if (tg == 4'h3) begin
                    chk("cfg_not_inside_tlp", 256'(in_tlp), 256'd0);
                    chk("cfg_expected", 256'(exp_cfg.size() != 0), 256'd1);
                    if (exp_cfg.size() != 0) begin
                        ec = exp_cfg.pop_front();
                        chk("cfg_dword", 256'(d), 256'(ec));
                    end
                end else begin
                    chk("tag_legal", 256'(tg), 256'hF);
                end
            end
        end
        chk("word_not_empty", 256'(used != 0), 256'd1);
    endtask

    // Source FIFOs: rd_en sampled mid-cycle, data presented 1 cycle later just after the edge.
    initial begin : fifo_model
        forever begin
            @(negedge clk);
            t_rd = tlp_rd_en;
            c_rd = cfg_rd_en;
            @(posedge clk);
            #1;
            tlp_valid = 1'b0;
            cfg_valid = 1'b0;
            if (!rst) begin
                if (t_rd) begin
                    chk("tlp_pop_nonempty", 256'(tlp_fifo.size() != 0), 256'd1);
                    if (tlp_fifo.size() != 0) begin
                        {tlp_last, tlp_data} = tlp_fifo.pop_front();
                        tlp_valid = 1'b1;
                        tlp_pops++;
                    end
                end
                if (c_rd) begin
                    chk("cfg_pop_nonempty", 256'(cfg_fifo.size() != 0), 256'd1);
                    if (cfg_fifo.size() != 0) begin
                        cfg_data  = cfg_fifo.pop_front();
                        cfg_valid = 1'b1;
                    end
                end
            end
            tlp_empty = (tlp_fifo.size() == 0) || tlp_hide;
            cfg_empty = (cfg_fifo.size() == 0) || cfg_hide;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                chk("ov_not_back_to_back", 256'(prev_ov), 256'd0);
                chk("no_arrival_in_emit", 256'(prev_arr), 256'd0);
                check_word(out_data);
            end
            prev_ov  = out_valid;
            prev_arr = tlp_valid | cfg_valid;
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t_rd0, t_ov, n_rd, n, k, p0, viol;
        int rdc [$];
        int ovc [$];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tlp_rd_en", 256'(tlp_rd_en), 256'd0);
        chk("rst_cfg_rd_en", 256'(cfg_rd_en), 256'd0);
        chk("rst_out_valid", 256'(out_valid), 256'd0);
        chk("rst_out_data", out_data, 256'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        // Stray valid on the first cycle after release must be ignored
        #1;
        tlp_valid = 1'b1;
        tlp_data  = 32'hDEAD_BEEF;
        tlp_last  = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_out_valid", 256'(out_valid), 256'd0);

        // Single CFG DWORD, flushed on timeout
        @(posedge clk);
        #2;
        push_cfg(32'hA5A5_0001);
        exp_words.push_back({32'hEFFF_FFF3, 192'h0, 32'hA5A5_0001});
        t_rd0 = -1;
        t_ov  = -1;
        n_rd  = 0;
        for (int c = 0; c < 300 && t_ov < 0; c++) begin
            @(negedge clk);
            if (cfg_rd_en) begin
                n_rd++;
                if (t_rd0 < 0) t_rd0 = c;
            end
            if (out_valid) t_ov = c;
        end
        chk("cfg_rd_pulses", 256'(n_rd), 256'd1);
        chk("cfg_flush_latency", 256'(t_ov - t_rd0), 256'd65);
        wait_drain("cfg_single", 200);

        // Single 10-DWORD TLP: one full word then a flushed partial
        @(posedge clk);
        #2;
        push_tlp(32'h100, 10);
        exp_words.push_back({32'hE111_1111, 32'h106, 32'h105, 32'h104, 32'h103, 32'h102,
                             32'h101, 32'h100});
        exp_words.push_back({32'hEFFF_F211, 128'h0, 32'h109, 32'h108, 32'h107});
        for (int c = 0; c < 400 && ovc.size() < 2; c++) begin
            @(negedge clk);
            if (tlp_rd_en) rdc.push_back(c);
            if (out_valid) ovc.push_back(c);
        end
        chk("tlp10_reads", 256'(rdc.size()), 256'd10);
        chk("tlp10_words", 256'(ovc.size()), 256'd2);
        if (rdc.size() == 10 && ovc.size() == 2) begin
            chk("tlp10_b2b_reads", 256'(rdc[6] - rdc[0]), 256'd6);
            chk("tlp10_first_emit", 256'(ovc[0] - rdc[0]), 256'd9);
            chk("tlp10_read_resume", 256'(rdc[7] - rdc[0]), 256'd9);
            chk("tlp10_flush_latency", 256'(ovc[1] - rdc[9]), 256'd65);
        end
        wait_drain("tlp10", 200);

        // Both sources non-empty: TLPs never interleaved with CFG
        @(posedge clk);
        #2;
        for (int p = 0; p < 4; p++) begin
            push_tlp(32'h400 + 32'(16 * p), 3);
            push_cfg(32'hC000_0000 + 32'(p));
        end
        wait_drain("mixed", 600);

        // Backpressure with a full word pending
        @(posedge clk);
        #2;
        push_tlp(32'h200, 8);
        exp_words.push_back({32'hE111_1111, 32'h206, 32'h205, 32'h204, 32'h203, 32'h202,
                             32'h201, 32'h200});
        exp_words.push_back({32'hEFFF_FFF2, 192'h0, 32'h207});
        n = 0;
        k = 0;
        while (n < 7 && k < 100) begin
            @(negedge clk);
            if (tlp_rd_en) n++;
            k++;
        end
        chk("bp_reads_before", 256'(n), 256'd7);
        @(posedge clk);
        #2;
        out_rd_en = 1'b0;
        viol = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || tlp_rd_en || cfg_rd_en) viol++;
        end
        chk("bp_hold_quiet", 256'(viol), 256'd0);
        @(posedge clk);
        #2;
        out_rd_en = 1'b1;
        @(negedge clk);
        chk("bp_release_same_cycle", 256'({out_valid, tlp_rd_en}), 256'd0);
        @(negedge clk);
        chk("bp_release_valid", 256'(out_valid), 256'd1);
        chk("bp_resume_read", 256'(tlp_rd_en), 256'd1);
        wait_drain("backpressure", 300);

        // Reset in the middle of a TLP
        @(posedge clk);
        #2;
        push_tlp(32'h300, 7);
        p0 = tlp_pops;
        k  = 0;
        while (tlp_pops < p0 + 4 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_pops", 256'(tlp_pops - p0), 256'd4);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_tlp_rd_en", 256'(tlp_rd_en), 256'd0);
        chk("rst_async_cfg_rd_en", 256'(cfg_rd_en), 256'd0);
        chk("rst_async_out_valid", 256'(out_valid), 256'd0);
        chk("rst_async_out_data", out_data, 256'd0);
        tlp_fifo.delete();
        cfg_fifo.delete();
        exp_tlp.delete();
        exp_cfg.delete();
        exp_words.delete();
        in_tlp = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        push_cfg(32'hC0DE_0001);
        exp_words.push_back({32'hEFFF_FFF3, 192'h0, 32'hC0DE_0001});
        wait_drain("rst_mid_tlp", 300);

        // Random soak of source emptiness and downstream backpressure
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #2;
            if (tlp_fifo.size() < 12 && $urandom_range(0, 5) == 0) begin
                push_tlp($urandom, int'($urandom_range(1, 5)));
            end
            if (cfg_fifo.size() < 4 && $urandom_range(0, 7) == 0) push_cfg($urandom);
            tlp_hide  = ($urandom_range(0, 3) == 0);
            cfg_hide  = ($urandom_range(0, 3) == 0);
            out_rd_en = ($urandom_range(0, 5) != 0);
        end
        @(posedge clk);
        #2;
        tlp_hide  = 1'b0;
        cfg_hide  = 1'b0;
        out_rd_en = 1'b1;
        wait_drain("soak", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
